// File: rtl/ipsxe_fft_ram_pkg.sv
`default_nettype none
// ============================================================================
// ipsxe_fft_ram_pkg : shared types and helpers for the FFT ping/pong RAM
// Revision 1.0
// ============================================================================
package ipsxe_fft_ram_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } ram_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int be_width(input int data_width, input int byte_size);
    return data_width / byte_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipsxe_fft_ram_core.sv
`default_nettype none
// ============================================================================
// ipsxe_fft_ram_core : byte-lane array with registered read and collision mux
// Revision 1.0
// ============================================================================
module ipsxe_fft_ram_core
  import ipsxe_fft_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 36,
  parameter int BYTE_SIZE  = 9,
  parameter int BYPASS_EN  = 1
) (
  input  logic                                clk,
  input  logic                                we_i,
  input  logic [ADDR_WIDTH-1:0]               waddr_i,
  input  logic [DATA_WIDTH-1:0]               wdata_i,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0]     wbe_i,
  input  logic                                re_i,
  input  logic [ADDR_WIDTH-1:0]               raddr_i,
  output logic [DATA_WIDTH-1:0]               rdata_o
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] lane_mask_w;
  logic [DATA_WIDTH-1:0] old_w;
  logic [DATA_WIDTH-1:0] rd_word_w;

  always_comb begin
    lane_mask_w = '0;
    for (int l = 0; l < BE_WIDTH; l++) begin
      lane_mask_w[l*BYTE_SIZE +: BYTE_SIZE] = {BYTE_SIZE{wbe_i[l]}};
    end
  end

  // Collision forwarding merges only the lanes being written this cycle.
  always_comb begin
    old_w     = mem_q[raddr_i];
    rd_word_w = old_w;
    if ((BYPASS_EN != 0) && we_i && (waddr_i == raddr_i)) begin
      rd_word_w = (old_w & ~lane_mask_w) | (wdata_i & lane_mask_w);
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < BE_WIDTH; l++) begin
        if (wbe_i[l]) mem_q[waddr_i][l*BYTE_SIZE +: BYTE_SIZE] <= wdata_i[l*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= rd_word_w;
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ipsxe_fft_sdpram_pipe.sv
`default_nettype none
// ============================================================================
// ipsxe_fft_sdpram_pipe : FFT stage RAM with clear engine and read pipeline
// Revision 1.0
// ============================================================================
module ipsxe_fft_sdpram_pipe
  import ipsxe_fft_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 36,
  parameter int BYTE_SIZE  = 9,
  parameter int RD_LATENCY = 2,
  parameter int BYPASS_EN  = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0] wr_byte_en,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  output logic                            init_busy
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);

  if ((DATA_WIDTH % BYTE_SIZE != 0) || ((BYTE_SIZE != 8) && (BYTE_SIZE != 9))) begin : g_bad_lanes
    $fatal(1, "ipsxe_fft_sdpram_pipe: DATA_WIDTH must be a multiple of BYTE_SIZE (8 or 9)");
  end
  if ((RD_LATENCY < RD_LAT_MIN) || (RD_LATENCY > RD_LAT_MAX)) begin : g_bad_latency
    $fatal(1, "ipsxe_fft_sdpram_pipe: RD_LATENCY must be 1, 2 or 3");
  end

  ram_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    in_clear_w, in_ready_w, rd_fire_w;
  logic                    mem_we_w;
  logic [ADDR_WIDTH-1:0]   mem_waddr_w;
  logic [DATA_WIDTH-1:0]   mem_wdata_w;
  logic [BE_WIDTH-1:0]     mem_wbe_w;
  logic [DATA_WIDTH-1:0]   core_rdata_w;
  logic [RD_LATENCY-1:0]   vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d   = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
        clr_cnt_d = '0;
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (&clr_cnt_q) state_d = ST_READY;
      end
      ST_READY: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign in_clear_w = (state_q == ST_CLEAR);
  assign in_ready_w = (state_q == ST_READY);
  assign rd_fire_w  = in_ready_w & rd_en;
  assign init_busy  = in_clear_w || ((state_q == ST_RESET) && (INIT_CLEAR != 0));

  // The sweep owns the write port; user writes only land in READY.
  assign mem_we_w    = in_clear_w | (in_ready_w & wr_en);
  assign mem_waddr_w = in_clear_w ? clr_cnt_q : wr_addr;
  assign mem_wdata_w = in_clear_w ? '0 : wr_data;
  assign mem_wbe_w   = in_clear_w ? '1 : wr_byte_en;

  ipsxe_fft_ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_SIZE  (BYTE_SIZE),
    .BYPASS_EN  (BYPASS_EN)
  ) u_core (
    .clk     (clk),
    .we_i    (mem_we_w),
    .waddr_i (mem_waddr_w),
    .wdata_i (mem_wdata_w),
    .wbe_i   (mem_wbe_w),
    .re_i    (rd_fire_w),
    .raddr_i (rd_addr),
    .rdata_o (core_rdata_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_fire_w;
      for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign rd_valid = vld_q[RD_LATENCY-1];

  if (RD_LATENCY == 1) begin : g_lat1
    // The array register has no reset, so mask it until the first read lands.
    logic seen_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         seen_q <= 1'b0;
      else if (rd_fire_w) seen_q <= 1'b1;
    end
    assign rd_data = seen_q ? core_rdata_w : '0;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] stage_q [1:RD_LATENCY-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < RD_LATENCY; i++) stage_q[i] <= '0;
      end else begin
        if (vld_q[0]) stage_q[1] <= core_rdata_w;
        for (int i = 2; i < RD_LATENCY; i++) begin
          if (vld_q[i-1]) stage_q[i] <= stage_q[i-1];
        end
      end
    end
    assign rd_data = stage_q[RD_LATENCY-1];
  end

endmodule
`default_nettype wire
